// File: rtl/boot_copy_master_if.sv
// Request/response valid-ready bus used by the on-chip memory responders.
// The initiator (boot_copy_master) uses the master modport, a memory responder uses the slave modport.
interface boot_copy_master_if;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic [31:0] data_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        rsp_valid_i;
    logic        rsp_ready_o;

    modport master (
        output addr_o,
        output data_o,
        output sel_o,
        output we_o,
        output req_valid_o,
        output rsp_ready_o,
        input  data_i,
        input  req_ready_i,
        input  rsp_valid_i
    );

    modport slave (
        input  addr_o,
        input  data_o,
        input  sel_o,
        input  we_o,
        input  req_valid_o,
        input  rsp_ready_o,
        output data_i,
        output req_ready_i,
        output rsp_valid_i
    );
endinterface

// File: rtl/boot_copy_master.sv
// Bus initiator that copies len_i words from a source slave to a destination slave, one transaction at a time.
// Optional feature macro BOOT_COPY_CHECKSUM_EN adds a running sum of every word read.
module boot_copy_master #(
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_W-1:0]     len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [LEN_W-1:0]     count_o,
    output logic [31:0]          checksum_o,
    boot_copy_master_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RSP,
        WR_REQ,
        WR_RSP,
        DONE
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t           state;
    logic [29:0]      src_word;
    logic [29:0]      dst_word;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] count_next;
    logic [31:0]      data;
    logic [31:0]      addr;
    logic             we;
    logic             req_valid;
    logic             rsp_ready;
    logic             busy;
    logic             done;
    logic             unused_addr_bits;

    assign count_next       = count + CNT_ONE;
    assign unused_addr_bits = ^{src_addr_i[1:0], dst_addr_i[1:0]};

    // Addresses are kept as word indices so the +4 step wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_word  <= '0;
            dst_word  <= '0;
            len       <= '0;
            count     <= '0;
            data      <= '0;
            addr      <= '0;
            we        <= 1'b0;
            req_valid <= 1'b0;
            rsp_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        count <= '0;
                        if (len_i != '0) begin
                            src_word  <= src_addr_i[31:2];
                            dst_word  <= dst_addr_i[31:2];
                            len       <= len_i;
                            addr      <= {src_addr_i[31:2], 2'b00};
                            we        <= 1'b0;
                            req_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= RD_REQ;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RD_REQ: begin
                    if (bus.req_ready_i) begin
                        req_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                        state     <= RD_RSP;
                    end
                end
                RD_RSP: begin
                    if (bus.rsp_valid_i) begin
                        data      <= bus.data_i;
                        rsp_ready <= 1'b0;
                        req_valid <= 1'b1;
                        we        <= 1'b1;
                        addr      <= {dst_word, 2'b00};
                        state     <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (bus.req_ready_i) begin
                        req_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                        state     <= WR_RSP;
                    end
                end
                WR_RSP: begin
                    if (bus.rsp_valid_i) begin
                        rsp_ready <= 1'b0;
                        count     <= count_next;
                        src_word  <= src_word + 30'd1;
                        dst_word  <= dst_word + 30'd1;
                        we        <= 1'b0;
                        if (count_next == len) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            req_valid <= 1'b1;
                            addr      <= {src_word + 30'd1, 2'b00};
                            state     <= RD_REQ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BOOT_COPY_CHECKSUM_EN
    logic [31:0] checksum;

    // Accumulates exactly the words accepted on read responses, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == IDLE && start_i) begin
            checksum <= '0;
        end else if (state == RD_RSP && bus.rsp_valid_i) begin
            checksum <= checksum + bus.data_i;
        end
    end

    assign checksum_o = checksum;
`else
    assign checksum_o = 32'h0;
`endif

    assign busy_o          = busy;
    assign done_o          = done;
    assign count_o         = count;
    assign bus.addr_o      = addr;
    assign bus.data_o      = data;
    assign bus.sel_o       = 4'hF;
    assign bus.we_o        = we;
    assign bus.req_valid_o = req_valid;
    assign bus.rsp_ready_o = rsp_ready;

endmodule

// File: tb/tb_boot_copy_master.sv
// Bench for boot_copy_master: a randomized memory responder plus a word-level copy model.
// Define BOOT_COPY_CHECKSUM_EN at compile time to also expect the running checksum.
module tb_boot_copy_master;
    localparam int LEN_W = 16;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len      = '0;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] count;
    logic [31:0]      checksum;

    boot_copy_master_if bus ();

    boot_copy_master #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .src_addr_i (src_addr),
        .dst_addr_i (dst_addr),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .count_o    (count),
        .checksum_o (checksum),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rom_q[$];
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];
    int stall_max   = 0;
    bit stall_fixed = 1'b1;
    int delay_max   = 0;
    bit noise_en    = 1'b0;
    int violations  = 0;
    int done_count  = 0;
    int busy_seen   = 0;
    int req_seen    = 0;

    // Responder: inputs change at negedge; a snapshot taken just after holds what the next posedge sees.
    initial begin : responder
        bit          pending       = 1'b0;
        int          rsp_wait      = 0;
        int          wait_cnt      = 0;
        logic [31:0] rsp_data      = '0;
        bit          snap_rst      = 1'b0;
        bit          snap_req_fire = 1'b0;
        bit          snap_rsp_fire = 1'b0;
        bit          hold          = 1'b0;
        logic        snap_we       = 1'b0;
        logic [31:0] snap_addr     = '0;
        logic [31:0] snap_data     = '0;
        bus.req_ready_i = 1'b0;
        bus.rsp_valid_i = 1'b0;
        bus.data_i      = '0;
        forever begin
            @(negedge clk);
            if (snap_rsp_fire) pending = 1'b0;
            if (snap_req_fire) begin
                if (snap_we) begin
                    mem[snap_addr] = snap_data;
                    wr_log.push_back(snap_addr);
                end else begin
                    rd_log.push_back(snap_addr);
                    rsp_data = mem.exists(snap_addr) ? mem[snap_addr] : 32'hDEAD_BEEF;
                end
                pending  = 1'b1;
                rsp_wait = (delay_max == 0) ? 0 : int'($urandom_range(0, delay_max));
                wait_cnt = stall_fixed ? stall_max : int'($urandom_range(0, stall_max));
            end
            if (!snap_rst) begin
                pending  = 1'b0;
                wait_cnt = 0;
            end
            if (pending) begin
                bus.req_ready_i = 1'b0;
                if (rsp_wait > 0) begin
                    rsp_wait--;
                    bus.rsp_valid_i = 1'b0;
                end else begin
                    bus.rsp_valid_i = 1'b1;
                    bus.data_i      = rsp_data;
                end
            end else begin
                bus.rsp_valid_i = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.data_i      = $urandom;
                if (bus.req_valid_o === 1'b1) begin
                    if (wait_cnt > 0) begin
                        wait_cnt--;
                        bus.req_ready_i = 1'b0;
                    end else begin
                        bus.req_ready_i = 1'b1;
                    end
                end else begin
                    bus.req_ready_i = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                    wait_cnt = stall_fixed ? stall_max : int'($urandom_range(0, stall_max));
                end
            end
            #1;
            if (hold && (bus.req_valid_o !== 1'b1 || bus.addr_o !== snap_addr ||
                         bus.data_o !== snap_data || bus.we_o !== snap_we))
                violations++;
            if (done === 1'b1) done_count++;
            if (busy === 1'b1) busy_seen++;
            if (bus.req_valid_o === 1'b1) req_seen++;
            snap_rst      = rst_n;
            snap_req_fire = rst_n && bus.req_valid_o && bus.req_ready_i;
            snap_rsp_fire = rst_n && bus.rsp_valid_i && bus.rsp_ready_o;
            hold          = rst_n && bus.req_valid_o && !bus.req_ready_i;
            snap_addr     = bus.addr_o;
            snap_data     = bus.data_o;
            snap_we       = bus.we_o;
        end
    end

    function automatic logic [31:0] word_addr(input logic [31:0] base, input int i);
        return {base[31:2], 2'b00} + 32'(4 * i);
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] exp_checksum();
`ifdef BOOT_COPY_CHECKSUM_EN
        logic [31:0] s = '0;
        foreach (rom_q[i]) s = s + rom_q[i];
        return s;
`else
        return 32'h0;
`endif
    endfunction

    task automatic load_rom(input logic [31:0] s);
        mem.delete();
        rd_log.delete();
        wr_log.delete();
        foreach (rom_q[i]) mem[word_addr(s, i)] = rom_q[i];
    endtask

    task automatic fill_rom(input int n);
        rom_q.delete();
        for (int i = 0; i < n; i++) rom_q.push_back($urandom);
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n, output int start_cyc);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len       = LEN_W'(n);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start    = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        len      = LEN_W'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit finished);
        finished = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, bus.we_o, bus.req_valid_o, bus.rsp_ready_o} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {busy, done, bus.we_o, bus.req_valid_o, bus.rsp_ready_o});
        end
        checks++;
        if (count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", count);
        end
        checks++;
        if (checksum !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_checksum: got %h expected 0", checksum);
        end
        checks++;
        if (bus.addr_o !== 32'h0 || bus.data_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_addr_data: got %h/%h expected 0/0", bus.addr_o, bus.data_o);
        end
        checks++;
        if (bus.sel_o !== 4'hF) begin
            errors++;
            $display("[TB] FAIL reset_sel: got %h expected f", bus.sel_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_copy();
        int sc;
        int lat;
        bit fin;
        stall_max = 0; stall_fixed = 1'b1; delay_max = 0; noise_en = 1'b0;
        rom_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        load_rom(32'h0);
        busy_seen = 0;
        do_start(32'h0, 32'h1000_0000, 4, sc);
        wait_done(200, fin);
        lat = cyc - sc;
        checks++;
        if (!fin) begin
            errors++;
            $display("[TB] FAIL basic_done_seen: got no done expected done");
        end
        checks++;
        if (lat != 17) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d expected 17", lat);
        end
        checks++;
        if (busy !== 1'b0 || count !== LEN_W'(4)) begin
            errors++;
            $display("[TB] FAIL basic_done_state: got busy=%b count=%0d expected busy=0 count=4", busy, count);
        end
        checks++;
        if (checksum !== exp_checksum()) begin
            errors++;
            $display("[TB] FAIL basic_checksum: got %h expected %h", checksum, exp_checksum());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_read(word_addr(32'h1000_0000, i)) !== rom_q[i]) begin
                errors++;
                $display("[TB] FAIL basic_word%0d: got %h expected %h", i,
                         mem_read(word_addr(32'h1000_0000, i)), rom_q[i]);
            end
        end
        @(negedge clk);
        #2;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done_pulse: got %b expected 0", done);
        end
        checks++;
        if (busy_seen != 16) begin
            errors++;
            $display("[TB] FAIL basic_busy_cycles: got %0d expected 16", busy_seen);
        end
    endtask

    task automatic test_stall();
        int sc;
        int lat;
        bit fin;
        stall_max = 3; stall_fixed = 1'b1; delay_max = 0; noise_en = 1'b0;
        violations = 0;
        fill_rom(5);
        load_rom(32'h0000_2000);
        do_start(32'h0000_2000, 32'h2000_0000, 5, sc);
        wait_done(400, fin);
        lat = cyc - sc;
        checks++;
        if (!fin || lat != 51) begin
            errors++;
            $display("[TB] FAIL stall_latency: got done=%b after %0d expected done after 51", fin, lat);
        end
        checks++;
        if (violations != 0) begin
            errors++;
            $display("[TB] FAIL stall_hold: got %0d unstable requests expected 0", violations);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_read(word_addr(32'h2000_0000, i)) !== rom_q[i]) begin
                errors++;
                $display("[TB] FAIL stall_word%0d: got %h expected %h", i,
                         mem_read(word_addr(32'h2000_0000, i)), rom_q[i]);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (count !== LEN_W'(5)) begin
            errors++;
            $display("[TB] FAIL stall_count_hold: got %0d expected 5", count);
        end
    endtask

    task automatic test_zero_len();
        int sc;
        int lat;
        bit fin;
        rom_q.delete();
        load_rom(32'h0);
        busy_seen = 0;
        req_seen  = 0;
        do_start(32'h0000_7000, 32'h7000_0000, 0, sc);
        wait_done(5, fin);
        lat = cyc - sc;
        checks++;
        if (!fin || lat != 1) begin
            errors++;
            $display("[TB] FAIL zero_latency: got done=%b after %0d expected done after 1", fin, lat);
        end
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (busy_seen != 0 || req_seen != 0) begin
            errors++;
            $display("[TB] FAIL zero_no_traffic: got busy=%0d req=%0d cycles expected 0/0", busy_seen, req_seen);
        end
        checks++;
        if (count !== '0 || rd_log.size() != 0 || wr_log.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_count: got count=%0d rd=%0d wr=%0d expected 0/0/0",
                     count, rd_log.size(), wr_log.size());
        end
    endtask

    task automatic test_wrap();
        int sc;
        bit fin;
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] got;
        s = 32'hFFFF_FFF8;
        d = 32'h0000_4003;
        stall_max = 2; stall_fixed = 1'b0; delay_max = 2; noise_en = 1'b1;
        fill_rom(3);
        load_rom(s);
        do_start(s, d, 3, sc);
        wait_done(200, fin);
        checks++;
        if (!fin || rd_log.size() != 3 || wr_log.size() != 3) begin
            errors++;
            $display("[TB] FAIL wrap_txn_count: got done=%b rd=%0d wr=%0d expected 1/3/3",
                     fin, rd_log.size(), wr_log.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < rd_log.size()) ? rd_log[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== word_addr(s, i)) begin
                errors++;
                $display("[TB] FAIL wrap_rd_addr%0d: got %h expected %h", i, got, word_addr(s, i));
            end
            got = (i < wr_log.size()) ? wr_log[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== word_addr(d, i)) begin
                errors++;
                $display("[TB] FAIL wrap_wr_addr%0d: got %h expected %h", i, got, word_addr(d, i));
            end
            checks++;
            if (mem_read(word_addr(d, i)) !== rom_q[i]) begin
                errors++;
                $display("[TB] FAIL wrap_word%0d: got %h expected %h", i, mem_read(word_addr(d, i)), rom_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_copy();
        int sc;
        int lat;
        int dc;
        bit fin;
        bit found;
        stall_max = 3; stall_fixed = 1'b1; delay_max = 0; noise_en = 1'b0;
        fill_rom(4);
        load_rom(32'h0000_3000);
        do_start(32'h0000_3000, 32'h3000_0000, 4, sc);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.req_valid_o === 1'b1 && bus.we_o === 1'b1 && count === LEN_W'(1)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL midreset_reach_wr2: got no second write request expected one");
        end
        rst_n = 1'b0;
        dc    = done_count;
        @(negedge clk);
        checks++;
        if (bus.req_valid_o !== 1'b0 || bus.rsp_ready_o !== 1'b0 || busy !== 1'b0 || count !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got req=%b rsp=%b busy=%b count=%0d expected 0/0/0/0",
                     bus.req_valid_o, bus.rsp_ready_o, busy, count);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        checks++;
        if (done_count != dc) begin
            errors++;
            $display("[TB] FAIL midreset_no_done: got %0d done pulses expected 0", done_count - dc);
        end
        load_rom(32'h0000_3000);
        do_start(32'h0000_3000, 32'h3000_0000, 4, sc);
        wait_done(400, fin);
        lat = cyc - sc;
        checks++;
        if (!fin || lat != 41 || wr_log.size() != 4) begin
            errors++;
            $display("[TB] FAIL midreset_restart: got done=%b lat=%0d writes=%0d expected 1/41/4",
                     fin, lat, wr_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_read(word_addr(32'h3000_0000, i)) !== rom_q[i]) begin
                errors++;
                $display("[TB] FAIL midreset_word%0d: got %h expected %h", i,
                         mem_read(word_addr(32'h3000_0000, i)), rom_q[i]);
            end
        end
    endtask

    task automatic test_checksum_ignore();
        int sc;
        bit fin;
        stall_max = 2; stall_fixed = 1'b0; delay_max = 1; noise_en = 1'b1;
        rom_q = '{32'hFFFF_FFFF, 32'h0000_0002};
        load_rom(32'h0000_5000);
        do_start(32'h0000_5000, 32'h5000_0000, 2, sc);
        for (int i = 0; i < 3; i++) begin
            src_addr = 32'h0000_6000;
            dst_addr = 32'h6000_0000;
            len      = LEN_W'(7);
            start    = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(200, fin);
        checks++;
        if (!fin || count !== LEN_W'(2) || wr_log.size() != 2) begin
            errors++;
            $display("[TB] FAIL ignore_start: got done=%b count=%0d writes=%0d expected 1/2/2",
                     fin, count, wr_log.size());
        end
        checks++;
        if (checksum !== exp_checksum()) begin
            errors++;
            $display("[TB] FAIL checksum_wrap: got %h expected %h", checksum, exp_checksum());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_read(word_addr(32'h5000_0000, i)) !== rom_q[i]) begin
                errors++;
                $display("[TB] FAIL ignore_word%0d: got %h expected %h", i,
                         mem_read(word_addr(32'h5000_0000, i)), rom_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sc;
        int n;
        bit fin;
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] got;
        stall_max = 3; stall_fixed = 1'b0; delay_max = 3; noise_en = 1'b1;
        for (int it = 0; it < 10; it++) begin
            n = int'($urandom_range(1, 8));
            s = $urandom;
            d = s ^ 32'h8000_0000;
            fill_rom(n);
            load_rom(s);
            do_start(s, d, n, sc);
            wait_done(30 * n + 20, fin);
            checks++;
            if (!fin || count !== LEN_W'(n) || wr_log.size() != n) begin
                errors++;
                $display("[TB] FAIL b2b_iter%0d_count: got done=%b count=%0d writes=%0d expected 1/%0d/%0d",
                         it, fin, count, wr_log.size(), n, n);
            end
            checks++;
            if (checksum !== exp_checksum()) begin
                errors++;
                $display("[TB] FAIL b2b_iter%0d_checksum: got %h expected %h", it, checksum, exp_checksum());
            end
            for (int i = 0; i < n; i++) begin
                got = (i < wr_log.size()) ? wr_log[i] : 32'hxxxx_xxxx;
                checks++;
                if (got !== word_addr(d, i) || mem_read(word_addr(d, i)) !== rom_q[i]) begin
                    errors++;
                    $display("[TB] FAIL b2b_iter%0d_word%0d: got addr %h data %h expected addr %h data %h",
                             it, i, got, mem_read(word_addr(d, i)), word_addr(d, i), rom_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_stall();
        test_zero_len();
        test_wrap();
        test_reset_mid_copy();
        test_checksum_ignore();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
